// File: rtl/lcd_pkg.sv
// Shared constants for the HD44780-style LCD write sequencer: command codes,
// FSM state encodings and the power-on init command ROM.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam int INIT_LEN = 6;

  typedef logic [2:0] state_t;
  localparam state_t ST_PWR_WAIT = 3'd0;
  localparam state_t ST_INIT     = 3'd1;
  localparam state_t ST_IDLE     = 3'd2;
  localparam state_t ST_DATA     = 3'd3;
  localparam state_t ST_CLEAR    = 3'd4;
  localparam state_t ST_LINE_FIX = 3'd5;

  typedef logic [1:0] phase_t;
  localparam phase_t PH_IDLE   = 2'd0;
  localparam phase_t PH_SETUP  = 2'd1;
  localparam phase_t PH_STROBE = 2'd2;
  localparam phase_t PH_EXEC   = 2'd3;

  function automatic logic [7:0] initCmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0, 3'd1, 3'd2: cmd = CMD_FUNC_SET;
      3'd3:             cmd = CMD_DISP_ON;
      3'd4:             cmd = CMD_CLEAR;
      default:          cmd = CMD_ENTRY;
    endcase
    return cmd;
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
  function automatic logic needsLongWait(input logic [7:0] cmd);
    return (cmd[7:2] == 6'd0) && (cmd[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One LCD write cycle: SETUP (E low), STROBE (E high), EXEC (E low, wait),
// with RS/data held throughout and a single-cycle done in the final cycle.
module lcd_bus_cycle #(
  parameter int E_SETUP_CYC    = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 82000
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  input  logic       long_wait_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       rs_o,
  output logic       e_o,
  output logic [7:0] data_o
);
  import lcd_pkg::*;

  // E must be high for at least one cycle to latch anything.
  localparam int STROBE_CYC = (E_HIGH_CYC > 0) ? E_HIGH_CYC : 1;
  localparam int MAX_AB  = (E_SETUP_CYC > STROBE_CYC) ? E_SETUP_CYC : STROBE_CYC;
  localparam int MAX_CD  = (SHORT_WAIT_CYC > LONG_WAIT_CYC) ? SHORT_WAIT_CYC : LONG_WAIT_CYC;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(E_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] SHORT_LAST  = CNT_W'(SHORT_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_WAIT_CYC - 1);

  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rs_q, rs_d;
  logic [7:0]       data_q, data_d;
  logic             longWait_q, longWait_d;
  logic [CNT_W-1:0] waitLast;
  logic             waitZero;

  assign waitLast = longWait_q ? LONG_LAST : SHORT_LAST;
  assign waitZero = longWait_q ? (LONG_WAIT_CYC == 0) : (SHORT_WAIT_CYC == 0);

  always_comb begin
    phase_d    = phase_q;
    cnt_d      = cnt_q + CNT_W'(1);
    rs_d       = rs_q;
    data_d     = data_q;
    longWait_d = longWait_q;
    done_o     = 1'b0;
    case (phase_q)
      PH_IDLE: begin
        cnt_d = '0;
        if (start_i) begin
          rs_d       = rs_i;
          data_d     = data_i;
          longWait_d = long_wait_i;
          phase_d    = (E_SETUP_CYC != 0) ? PH_SETUP : PH_STROBE;
        end
      end
      PH_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          phase_d = PH_STROBE;
        end
      end
      PH_STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          cnt_d = '0;
          if (waitZero) begin
            phase_d = PH_IDLE;
            done_o  = 1'b1;
          end else begin
            phase_d = PH_EXEC;
          end
        end
      end
      PH_EXEC: begin
        if (cnt_q == waitLast) begin
          cnt_d   = '0;
          phase_d = PH_IDLE;
          done_o  = 1'b1;
        end
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      phase_q    <= PH_IDLE;
      cnt_q      <= '0;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
      longWait_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
      longWait_q <= longWait_d;
    end
  end

  assign busy_o = (phase_q != PH_IDLE);
  assign e_o    = (phase_q == PH_STROBE);
  assign rs_o   = rs_q;
  assign data_o = data_q;

endmodule

// File: rtl/lcd_write_sequencer.sv
// LCD write sequencer: power-on wait, init ROM, char/clear handshake and
// cursor tracking with DDRAM re-addressing at line ends on a 2xCOLS display.
module lcd_write_sequencer #(
  parameter int PWR_WAIT_CYC   = 750000,
  parameter int E_SETUP_CYC    = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 82000,
  parameter int COLS           = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  input  logic       clear_req,
  output logic       init_done,
  output logic       RW_lcd,
  output logic       RS_lcd,
  output logic       E_lcd,
  output logic [7:0] data_lcd
);
  import lcd_pkg::*;

  localparam int PWR_W = (PWR_WAIT_CYC > 1) ? $clog2(PWR_WAIT_CYC) : 1;
  localparam logic [PWR_W-1:0] PWR_LAST  = PWR_W'(PWR_WAIT_CYC - 1);
  localparam logic [4:0]       COL_LINE2 = 5'(COLS);
  localparam logic [4:0]       COL_LAST  = 5'(2 * COLS - 1);
  localparam logic [2:0]       INIT_LAST = 3'(INIT_LEN - 1);
  localparam state_t ST_RESET = (PWR_WAIT_CYC == 0) ? ST_INIT : ST_PWR_WAIT;

  state_t           state_q, state_d;
  logic [PWR_W-1:0] pwrCnt_q, pwrCnt_d;
  logic [2:0]       initIdx_q, initIdx_d;
  logic [4:0]       col_q, col_d;
  logic             initDone_q, initDone_d;

  logic       busStart, busRs, busLong, busBusy, busDone;
  logic [7:0] busData;

  // col is advanced at accept, so in ST_DATA it already holds the post-write
  // column: COLS means line 1 just filled, 0 means line 2 just wrapped.
  always_comb begin
    state_d    = state_q;
    pwrCnt_d   = pwrCnt_q;
    initIdx_d  = initIdx_q;
    col_d      = col_q;
    initDone_d = initDone_q;
    busStart   = 1'b0;
    busRs      = 1'b0;
    busData    = 8'h00;
    busLong    = 1'b0;
    case (state_q)
      ST_PWR_WAIT: begin
        pwrCnt_d = pwrCnt_q + PWR_W'(1);
        if (pwrCnt_q == PWR_LAST) begin
          pwrCnt_d = '0;
          state_d  = ST_INIT;
        end
      end
      ST_INIT: begin
        if (!busBusy) begin
          busStart = 1'b1;
          busData  = initCmd(initIdx_q);
          busLong  = needsLongWait(busData);
        end else if (busDone) begin
          if (initIdx_q == INIT_LAST) begin
            initIdx_d  = 3'd0;
            initDone_d = 1'b1;
            col_d      = 5'd0;
            state_d    = ST_IDLE;
          end else begin
            initIdx_d = initIdx_q + 3'd1;
          end
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          busStart = 1'b1;
          busData  = CMD_CLEAR;
          busLong  = 1'b1;
          col_d    = 5'd0;
          state_d  = ST_CLEAR;
        end else if (char_valid) begin
          busStart = 1'b1;
          busRs    = 1'b1;
          busData  = char_data;
          col_d    = (col_q == COL_LAST) ? 5'd0 : col_q + 5'd1;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (busDone) begin
          state_d = ((col_q == COL_LINE2) || (col_q == 5'd0)) ? ST_LINE_FIX : ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (busDone) begin
          state_d = ST_IDLE;
        end
      end
      ST_LINE_FIX: begin
        if (!busBusy) begin
          busStart = 1'b1;
          busData  = (col_q == COL_LINE2) ? CMD_LINE2 : CMD_LINE1;
        end else if (busDone) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_RESET;
      pwrCnt_q   <= '0;
      initIdx_q  <= 3'd0;
      col_q      <= 5'd0;
      initDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pwrCnt_q   <= pwrCnt_d;
      initIdx_q  <= initIdx_d;
      col_q      <= col_d;
      initDone_q <= initDone_d;
    end
  end

  lcd_bus_cycle #(
    .E_SETUP_CYC   (E_SETUP_CYC),
    .E_HIGH_CYC    (E_HIGH_CYC),
    .SHORT_WAIT_CYC(SHORT_WAIT_CYC),
    .LONG_WAIT_CYC (LONG_WAIT_CYC)
  ) u_bus (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .start_i    (busStart),
    .rs_i       (busRs),
    .data_i     (busData),
    .long_wait_i(busLong),
    .busy_o     (busBusy),
    .done_o     (busDone),
    .rs_o       (RS_lcd),
    .e_o        (E_lcd),
    .data_o     (data_lcd)
  );

  assign char_ready = (state_q == ST_IDLE);
  assign init_done  = initDone_q;
  assign RW_lcd     = 1'b0;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: bus monitor with an expected-write queue,
// a table of character vectors, and hand sequences for clear and reset.
module tb_lcd_write_sequencer;

  localparam int PWR   = 20;
  localparam int SETUP = 2;
  localparam int HIGH  = 3;
  localparam int SHORT = 5;
  localparam int LONG  = 10;
  localparam int COLS  = 16;
  localparam int BUS_SHORT = 1 + SETUP + HIGH + SHORT;
  localparam int BUS_LONG  = 1 + SETUP + HIGH + LONG;
  localparam int NVEC = 48;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       char_valid = 1'b0;
  logic       clear_req = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready, init_done, RW_lcd, RS_lcd, E_lcd;
  logic [7:0] data_lcd;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  lcd_write_sequencer #(
    .PWR_WAIT_CYC  (PWR),
    .E_SETUP_CYC   (SETUP),
    .E_HIGH_CYC    (HIGH),
    .SHORT_WAIT_CYC(SHORT),
    .LONG_WAIT_CYC (LONG),
    .COLS          (COLS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .char_valid(char_valid),
    .char_data (char_data),
    .char_ready(char_ready),
    .clear_req (clear_req),
    .init_done (init_done),
    .RW_lcd    (RW_lcd),
    .RS_lcd    (RS_lcd),
    .E_lcd     (E_lcd),
    .data_lcd  (data_lcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       clr;
    logic       valid;
    logic [7:0] ch;
    logic       expRs;
    logic [7:0] expData;
    logic [7:0] expFix;
    int         expLat;
  } vec_t;

  exp_t expQ[$];
  int   riseQ[$];
  int   fallQ[$];
  vec_t vecs[NVEC];
  int   dataBeforeInit = 0;

  logic       prevE = 1'b0;
  int         riseCyc = 0;
  logic       riseRs = 1'b0;
  logic [7:0] riseData = 8'h00;
  exp_t       monExp;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic rs, input logic [7:0] d);
    exp_t e;
    e.rs = rs;
    e.data = d;
    expQ.push_back(e);
  endtask

  // Every completed E pulse is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      prevE = 1'b0;
    end else begin
      if (E_lcd && !prevE) begin
        riseCyc  = cyc;
        riseRs   = RS_lcd;
        riseData = data_lcd;
        riseQ.push_back(cyc);
        if (RS_lcd && !init_done) dataBeforeInit++;
      end else if (!E_lcd && prevE) begin
        fallQ.push_back(cyc);
        checkOutput("pulseWidth", cyc - riseCyc, HIGH);
        checkOutput("busHold", int'({RS_lcd, data_lcd}), int'({riseRs, riseData}));
        if (expQ.size() == 0) begin
          checkOutput("queueDepth", expQ.size(), 1);
        end else begin
          monExp = expQ.pop_front();
          checkOutput("pulseRs", int'(riseRs), int'(monExp.rs));
          checkOutput("pulseData", int'(riseData), int'(monExp.data));
        end
      end
      prevE = E_lcd;
    end
  end

  task automatic waitReady(input string name, input int limit);
    int n = 0;
    while (!char_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!char_ready) checkOutput(name, int'(char_ready), 1);
  endtask

  task automatic applyStimulus(input logic clr, input logic valid, input logic [7:0] ch,
                               output int acc);
    clear_req  = clr;
    char_valid = valid;
    char_data  = ch;
    acc = cyc;
  endtask

  task automatic releaseReset(output int rel);
    riseQ.delete();
    fallQ.delete();
    pushExp(1'b0, 8'h38);
    pushExp(1'b0, 8'h38);
    pushExp(1'b0, 8'h38);
    pushExp(1'b0, 8'h0C);
    pushExp(1'b0, 8'h01);
    pushExp(1'b0, 8'h06);
    reset_n = 1'b1;
    rel = cyc;
  endtask

  task automatic checkInit(input int rel);
    int gap;
    waitReady("initReadyTimeout", 400);
    checkOutput("initDone", int'(init_done), 1);
    checkOutput("initPulseCount", riseQ.size(), 6);
    checkOutput("initQueueEmpty", expQ.size(), 0);
    if (riseQ.size() == 6 && fallQ.size() == 6) begin
      checkOutput("pwrWaitQuiet", int'((riseQ[0] - rel) >= PWR), 1);
      for (int k = 0; k < 5; k++) begin
        gap = ((k == 4) ? LONG : SHORT) + SETUP + 1;
        checkOutput("initGap", riseQ[k+1] - fallQ[k], gap);
      end
      checkOutput("initDoneLatency", cyc - fallQ[5], SHORT);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rel;
    int acc;
    int n;

    for (int i = 0; i < NVEC; i++) begin
      vecs[i].clr     = 1'b0;
      vecs[i].valid   = 1'b1;
      vecs[i].ch      = 8'h30 + 8'(i % 16);
      vecs[i].expRs   = 1'b1;
      vecs[i].expData = vecs[i].ch;
      vecs[i].expFix  = (i == 15 || i == 47) ? 8'hC0 : (i == 31) ? 8'h80 : 8'h00;
      vecs[i].expLat  = (vecs[i].expFix != 8'h00) ? 2 * BUS_SHORT : BUS_SHORT;
    end

    repeat (3) @(negedge clk);
    checkOutput("resetRS", int'(RS_lcd), 0);
    checkOutput("resetE", int'(E_lcd), 0);
    checkOutput("resetData", int'(data_lcd), 0);
    checkOutput("resetRW", int'(RW_lcd), 0);
    checkOutput("resetReady", int'(char_ready), 0);
    checkOutput("resetInitDone", int'(init_done), 0);

    releaseReset(rel);
    checkInit(rel);

    $display("[TB] single character 0x41 timing");
    pushExp(1'b1, 8'h41);
    applyStimulus(1'b0, 1'b1, 8'h41, acc);
    for (int k = 1; k <= BUS_SHORT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        char_valid = 1'b0;
        checkOutput("acceptRs", int'(RS_lcd), 1);
        checkOutput("acceptData", int'(data_lcd), 8'h41);
        checkOutput("readyDrop", int'(char_ready), 0);
      end
      checkOutput("strobeE", int'(E_lcd), int'(k >= 1 + SETUP && k <= SETUP + HIGH));
    end
    checkOutput("readyReturn", int'(char_ready), 1);
    checkOutput("readyCycle", cyc - acc, BUS_SHORT);

    $display("[TB] clear and char together");
    pushExp(1'b0, 8'h01);
    applyStimulus(1'b1, 1'b1, 8'h5A, acc);
    @(negedge clk);
    clear_req = 1'b0;
    checkOutput("clearRs", int'(RS_lcd), 0);
    checkOutput("clearData", int'(data_lcd), 8'h01);
    waitReady("clearReadyTimeout", 100);
    checkOutput("clearLatency", cyc - acc, BUS_LONG);
    pushExp(1'b1, 8'h5A);
    acc = cyc;
    @(negedge clk);
    char_valid = 1'b0;
    checkOutput("heldCharData", int'(data_lcd), 8'h5A);
    waitReady("heldCharTimeout", 100);
    checkOutput("heldCharLatency", cyc - acc, BUS_SHORT);

    pushExp(1'b0, 8'h01);
    applyStimulus(1'b1, 1'b0, 8'h00, acc);
    @(negedge clk);
    clear_req = 1'b0;
    waitReady("clear2Timeout", 100);
    checkOutput("clear2Latency", cyc - acc, BUS_LONG);

    $display("[TB] character table across line ends");
    for (int i = 0; i < NVEC; i++) begin
      waitReady("vecReadyTimeout", 100);
      pushExp(vecs[i].expRs, vecs[i].expData);
      if (vecs[i].expFix != 8'h00) pushExp(1'b0, vecs[i].expFix);
      applyStimulus(vecs[i].clr, vecs[i].valid, vecs[i].ch, acc);
      @(negedge clk);
      char_valid = 1'b0;
      checkOutput("vecRs", int'(RS_lcd), int'(vecs[i].expRs));
      checkOutput("vecData", int'(data_lcd), int'(vecs[i].expData));
      waitReady("vecDoneTimeout", 100);
      checkOutput("vecLatency", cyc - acc, vecs[i].expLat);
    end

    $display("[TB] reset during strobe");
    pushExp(1'b1, 8'h77);
    applyStimulus(1'b0, 1'b1, 8'h77, acc);
    @(negedge clk);
    char_valid = 1'b0;
    n = 0;
    while (!E_lcd && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("strobeReached", int'(E_lcd), 1);
    reset_n = 1'b0;
    char_valid = 1'b1;
    char_data = 8'h55;
    @(negedge clk);
    checkOutput("midResetE", int'(E_lcd), 0);
    checkOutput("midResetReady", int'(char_ready), 0);
    checkOutput("midResetRS", int'(RS_lcd), 0);
    checkOutput("midResetInitDone", int'(init_done), 0);
    expQ.delete();
    repeat (2) @(negedge clk);

    releaseReset(rel);
    checkInit(rel);
    checkOutput("noEarlyData", dataBeforeInit, 0);
    pushExp(1'b1, 8'h55);
    acc = cyc;
    @(negedge clk);
    char_valid = 1'b0;
    checkOutput("firstCharRs", int'(RS_lcd), 1);
    checkOutput("firstCharData", int'(data_lcd), 8'h55);
    waitReady("firstCharTimeout", 100);
    checkOutput("firstCharLatency", cyc - acc, BUS_SHORT);
    checkOutput("finalQueue", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Controller that sequences the HD44780-style 8-bit LCD bus.
- After reset it runs the power-on init command list. It then accepts ASCII characters through a valid/ready handshake, plus a clear request, and emits correctly timed RS/RW/E/data write cycles.
- It tracks the cursor on a 2x16 display and inserts DDRAM-address commands at line ends.
- It sits between the button/debounce front end and the LCD pins, replacing free-running direct writes.

Parameters:
- PWR_WAIT_CYC, 750000, cycles of idle after reset before the first command (15 ms at 50 MHz).
- E_SETUP_CYC, 2, cycles RS/data are stable before E rises.
- E_HIGH_CYC, 12, cycles E is held high.
- SHORT_WAIT_CYC, 2000, execution wait after a normal command or data write (40 us).
- LONG_WAIT_CYC, 82000, execution wait after clear (0x01) or return-home (1.64 ms).
- COLS, 16, characters per line.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- char_valid  in  1  requester has a character
- char_data  in  8  ASCII code
- char_ready  out  1  sequencer will accept a char or clear this cycle
- clear_req  in  1  request display clear, level-sampled when char_ready=1
- init_done  out  1  init sequence complete (sticky until reset)
- RW_lcd  out  1  read/write select, constant 0
- RS_lcd  out  1  0 = command, 1 = data
- E_lcd  out  1  enable strobe
- data_lcd  out  8  LCD data bus

Behaviour:
- Reset is synchronous, active-low on clk edge. Reset values:
  - RS_lcd=0, E_lcd=0, data_lcd=0x00, RW_lcd=0, char_ready=0, init_done=0
  - cursor col=0, state=PWR_WAIT, all counters 0
- Reset asserted mid-cycle (including while E is high): E drops on the reset edge. The sequence restarts from PWR_WAIT; no partial write is completed.
- States:
  - PWR_WAIT: count PWR_WAIT_CYC cycles, then go to INIT.
  - INIT: issue ROM commands in order 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. Each is a full write cycle with RS=0. 0x01 uses LONG_WAIT_CYC; the others use SHORT_WAIT_CYC. After the last, init_done=1, col=0, go to IDLE.
  - IDLE: char_ready=1.
    - clear_req=1: accept clear. Issue 0x01 (LONG wait), col:=0. clear_req has priority over char_valid in the same cycle; the char is not consumed.
    - Otherwise char_valid=1: accept. Issue data write with RS=1, data=char_data latched at acceptance.
  - WRITE (shared sub-sequence for every command/data write):
    - SETUP: RS/data driven, E=0, for E_SETUP_CYC cycles.
    - STROBE: E=1 for E_HIGH_CYC cycles, RS/data unchanged.
    - EXEC: E=0, RS/data held, for the selected wait count. Then return to the caller state.
  - LINE_FIX: entered after a data write whose pre-write col was COLS-1 or 2*COLS-1. Issue 0xC0 (line 2 start) or 0x80 (line 1 start) respectively, SHORT wait, then IDLE.
- Handshake and latency:
  - Accept occurs on the edge where char_valid&char_ready (or clear_req&char_ready).
  - char_ready is 0 from the next cycle until IDLE is re-entered.
  - RS/data are valid at accept+1.
  - E rises at accept+1+E_SETUP_CYC and falls after E_HIGH_CYC cycles.
  - Next char_ready = accept + 1 + E_SETUP_CYC + E_HIGH_CYC + wait (+ a further full cycle if LINE_FIX runs).
- Cursor arithmetic:
  - col is 5 bits, range 0..2*COLS-1.
  - Increments by 1 on each data write; 2*COLS-1 wraps to 0 (line 1).
  - Reset and clear both set col=0.
- char_data/clear_req changes while not ready are ignored. char_ready=0 throughout PWR_WAIT and INIT.
- Counters are sized by $clog2 of the largest wait parameter. A wait parameter of 0 skips that phase (zero-length, no extra cycle).

Decomposition:
- Shared package `lcd_pkg`:
  - command constants CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY=0x06, CMD_LINE1=0x80, CMD_LINE2=0xC0
  - state enum
  - INIT_LEN=6
- One sub-module, `lcd_bus_cycle`:
  - takes start, rs, data, long_wait
  - drives RS/E/data with SETUP/STROBE/EXEC timing
  - returns done for one cycle
- The top holds the PWR_WAIT/INIT/IDLE/LINE_FIX FSM, the init ROM and the cursor.

Test Plan:
Bench parameters: PWR_WAIT_CYC=20, E_SETUP_CYC=2, E_HIGH_CYC=3, SHORT_WAIT_CYC=5, LONG_WAIT_CYC=10, COLS=16.
- Release reset -> E stays 0 for 20 cycles. Six E pulses carry 0x38,0x38,0x38,0x0C,0x01,0x06, all RS=0. Each E high lasts exactly 3 cycles. Gap after 0x01 is 10 wait cycles. Then init_done=1 and char_ready=1.
- After init, drive char_valid with 0x41 for one accept -> RS=1, data=0x41 at accept+1. E high from accept+3 to accept+5. char_ready returns at accept+11.
- Send 16 chars 0x30..0x3F -> the 16th data write is followed by a command 0xC0 (RS=0). Send 16 more -> 0x80 follows the 32nd; col wraps to 0.
- Assert clear_req and char_valid (0x5A) together in IDLE -> 0x01 is issued with LONG wait and col=0. 0x5A is accepted on the next ready.
- Assert reset_n=0 during STROBE of a data write -> E=0 and char_ready=0 on the next edge. After release, the full init repeats from PWR_WAIT.
- Hold char_valid=1 during PWR_WAIT/INIT -> no data write occurs before init_done. The first char is accepted on the first char_ready cycle.
